// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and IDLE/RUN/HALT sequencing.
// Control priority in RUN: branch > stall > jump > stop > flush > normal fetch.
//
// state | meaning
// IDLE  | waiting for start_i; PC held, IF/ID loaded with bubbles
// RUN   | fetching one instruction per cycle
// HALT  | stop decoded; PC frozen, bubbles only, left only through reset
module if_stage #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  stall_IF_ID_i,
    input  logic                  flush_IF_ID_i,
    input  logic                  JumpD_i,
    input  logic [ADDR_WIDTH-1:0] jumpAddr_i,
    input  logic                  StopD_i,
    input  logic                  BranchTakenE_i,
    input  logic [ADDR_WIDTH-1:0] branchAddrE_i,
    output logic [ADDR_WIDTH-1:0] instruction_mem_addr_o,
    input  logic [DATA_WIDTH-1:0] instruction_mem_rD_i,
    output logic [DATA_WIDTH-1:0] instrD_o,
    output logic [ADDR_WIDTH-1:0] PCD_o,
    output logic                  validD_o,
    output logic                  halted_o,
    output logic [15:0]           fetch_count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   pcf, pcf_next;
    logic [DATA_WIDTH-1:0]   instr_d, instr_next;
    logic [ADDR_WIDTH-1:0]   pcd, pcd_next;
    logic                    valid_d, valid_next;
    logic [15:0]             count, count_next;
    logic [ADDR_WIDTH-1:0]   pcf_inc;

    assign pcf_inc = pcf + ADDR_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            pcf     <= '0;
            instr_d <= NOP_INSTR;
            pcd     <= '0;
            valid_d <= 1'b0;
            count   <= '0;
        end else begin
            state   <= state_next;
            pcf     <= pcf_next;
            instr_d <= instr_next;
            pcd     <= pcd_next;
            valid_d <= valid_next;
            count   <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        pcf_next   = pcf;
        instr_next = NOP_INSTR;
        pcd_next   = '0;
        valid_next = 1'b0;
        count_next = count;
        case (state)
            IDLE: begin
                if (start_i) state_next = RUN;
            end
            RUN: begin
                if (BranchTakenE_i) begin
                    pcf_next = branchAddrE_i;
                end else if (stall_IF_ID_i) begin
                    // A stall freezes the IF/ID register rather than bubbling it.
                    instr_next = instr_d;
                    pcd_next   = pcd;
                    valid_next = valid_d;
                end else if (JumpD_i) begin
                    pcf_next = jumpAddr_i;
                end else if (StopD_i) begin
                    state_next = HALT;
                end else if (flush_IF_ID_i) begin
                    pcf_next = pcf_inc;
                end else begin
                    pcf_next   = pcf_inc;
                    instr_next = instruction_mem_rD_i;
                    pcd_next   = pcf;
                    valid_next = 1'b1;
                    count_next = (count == 16'hFFFF) ? count : count + 16'd1;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign instruction_mem_addr_o = pcf;
    assign instrD_o               = instr_d;
    assign PCD_o                  = pcd;
    assign validD_o               = valid_d;
    assign halted_o               = (state == HALT);
    assign fetch_count_o          = count;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios, random control traffic and a
// long run to exercise PC wrap and fetch counter saturation against a behavioural model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        stall_IF_ID_i = 1'b0;
    logic        flush_IF_ID_i = 1'b0;
    logic        JumpD_i = 1'b0;
    logic [7:0]  jumpAddr_i = 8'h00;
    logic        StopD_i = 1'b0;
    logic        BranchTakenE_i = 1'b0;
    logic [7:0]  branchAddrE_i = 8'h00;
    logic [7:0]  instruction_mem_addr_o;
    logic [15:0] instruction_mem_rD_i;
    logic [15:0] instrD_o;
    logic [7:0]  PCD_o;
    logic        validD_o;
    logic        halted_o;
    logic [15:0] fetch_count_o;

    logic [15:0] mem [256];

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: plain integers and flags, no state encoding.
    bit m_running = 0;
    bit m_halted  = 0;
    int m_pc      = 0;
    int m_instr   = 0;
    int m_pcd     = 0;
    bit m_valid   = 0;
    int m_count   = 0;

    if_stage #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .NOP_INSTR(16'h0000)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .start_i                (start_i),
        .stall_IF_ID_i          (stall_IF_ID_i),
        .flush_IF_ID_i          (flush_IF_ID_i),
        .JumpD_i                (JumpD_i),
        .jumpAddr_i             (jumpAddr_i),
        .StopD_i                (StopD_i),
        .BranchTakenE_i         (BranchTakenE_i),
        .branchAddrE_i          (branchAddrE_i),
        .instruction_mem_addr_o (instruction_mem_addr_o),
        .instruction_mem_rD_i   (instruction_mem_rD_i),
        .instrD_o               (instrD_o),
        .PCD_o                  (PCD_o),
        .validD_o               (validD_o),
        .halted_o               (halted_o),
        .fetch_count_o          (fetch_count_o)
    );

    always #5 clk = ~clk;

    assign instruction_mem_rD_i = mem[instruction_mem_addr_o];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bubble();
        m_instr = 0;
        m_pcd   = 0;
        m_valid = 0;
    endtask

    task automatic model_step();
        if (!rst) begin
            m_running = 0; m_halted = 0; m_pc = 0; m_count = 0;
            bubble();
        end else if (m_halted) begin
            bubble();
        end else if (!m_running) begin
            bubble();
            if (start_i) m_running = 1;
        end else if (BranchTakenE_i) begin
            m_pc = branchAddrE_i;
            bubble();
        end else if (stall_IF_ID_i) begin
            // everything holds
        end else if (JumpD_i) begin
            m_pc = jumpAddr_i;
            bubble();
        end else if (StopD_i) begin
            m_running = 0;
            m_halted  = 1;
            bubble();
        end else if (flush_IF_ID_i) begin
            bubble();
            m_pc = (m_pc + 1) % 256;
        end else begin
            m_instr = mem[m_pc];
            m_pcd   = m_pc;
            m_valid = 1;
            m_count = (m_count >= 65535) ? 65535 : m_count + 1;
            m_pc    = (m_pc + 1) % 256;
        end
    endtask

    task automatic check_all();
        chk("pcf",     32'(instruction_mem_addr_o), 32'(m_pc));
        chk("instrD",  32'(instrD_o),               32'(m_instr));
        chk("pcD",     32'(PCD_o),                  32'(m_pcd));
        chk("validD",  32'(validD_o),               32'(m_valid));
        chk("halted",  32'(halted_o),               32'(m_halted));
        chk("count",   32'(fetch_count_o),          32'(m_count));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic clear_ctl();
        start_i = 0; stall_IF_ID_i = 0; flush_IF_ID_i = 0; JumpD_i = 0;
        StopD_i = 0; BranchTakenE_i = 0; jumpAddr_i = 8'h00; branchAddrE_i = 8'h00;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);

        // Reset with noisy inputs, which must be ignored.
        rst = 0; start_i = 1; JumpD_i = 1; jumpAddr_i = 8'h33;
        cycle();
        cycle();
        clear_ctl();
        chk("reset_pcf", 32'(instruction_mem_addr_o), 32'h0);
        chk("reset_valid", 32'(validD_o), 32'h0);

        // Start pulse, then sequential fetch.
        rst = 1; start_i = 1;
        cycle();
        start_i = 0;
        cycle();
        chk("first_instr", 32'(instrD_o), 32'h1000);
        cycle();
        cycle();
        chk("third_instr", 32'(instrD_o), 32'h1002);
        chk("third_count", 32'(fetch_count_o), 32'd3);
        for (int i = 0; i < 20 && m_pc != 5; i++) cycle();

        // Stall three cycles at PCF=5.
        stall_IF_ID_i = 1;
        repeat (3) cycle();
        chk("stall_pcf", 32'(instruction_mem_addr_o), 32'h5);
        stall_IF_ID_i = 0;
        cycle();
        chk("resume_pcd", 32'(PCD_o), 32'h5);
        for (int i = 0; i < 20 && m_pc != 7; i++) cycle();

        // Jump at PCF=7 to 0x40.
        JumpD_i = 1; jumpAddr_i = 8'h40;
        cycle();
        clear_ctl();
        chk("jump_pcf", 32'(instruction_mem_addr_o), 32'h40);
        cycle();
        chk("jump_target_instr", 32'(instrD_o), 32'h1040);
        cycle();

        // Branch beats stall and stop.
        BranchTakenE_i = 1; branchAddrE_i = 8'h20; stall_IF_ID_i = 1; StopD_i = 1;
        JumpD_i = 1; jumpAddr_i = 8'h77;
        cycle();
        clear_ctl();
        chk("branch_pcf", 32'(instruction_mem_addr_o), 32'h20);
        chk("branch_not_halted", 32'(halted_o), 32'h0);
        cycle();

        // Flush only, then stop beats flush.
        flush_IF_ID_i = 1;
        cycle();
        flush_IF_ID_i = 0;
        cycle();
        StopD_i = 1; flush_IF_ID_i = 1;
        cycle();
        clear_ctl();
        chk("stop_halted", 32'(halted_o), 32'h1);
        for (int i = 0; i < 4; i++) begin
            start_i = 1; JumpD_i = i[0];
            cycle();
        end
        clear_ctl();
        rst = 0;
        cycle();
        rst = 1;
        chk("halt_reset_pcf", 32'(instruction_mem_addr_o), 32'h0);
        chk("halt_reset_halted", 32'(halted_o), 32'h0);

        // Random traffic with random IM contents and occasional resets.
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 600; i++) begin
            rst            = ($urandom_range(0, 99) != 0);
            start_i        = ($urandom_range(0, 7) == 0);
            BranchTakenE_i = ($urandom_range(0, 15) == 0);
            branchAddrE_i  = 8'($urandom);
            stall_IF_ID_i  = ($urandom_range(0, 7) == 0);
            JumpD_i        = ($urandom_range(0, 11) == 0);
            jumpAddr_i     = 8'($urandom);
            StopD_i        = ($urandom_range(0, 39) == 0);
            flush_IF_ID_i  = ($urandom_range(0, 9) == 0);
            cycle();
        end
        clear_ctl();

        // PC wrap and counter saturation on an uninterrupted run.
        rst = 0;
        cycle();
        rst = 1; start_i = 1;
        cycle();
        start_i = 0; JumpD_i = 1; jumpAddr_i = 8'hFE;
        cycle();
        clear_ctl();
        cycle();
        chk("wrap_pcd_fe", 32'(PCD_o), 32'hFE);
        cycle();
        chk("wrap_pcd_ff", 32'(PCD_o), 32'hFF);
        cycle();
        chk("wrap_pcd_00", 32'(PCD_o), 32'h00);
        for (int i = 0; i < 65540; i++) cycle();
        chk("count_saturated", 32'(fetch_count_o), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 16, instruction width; ADDR_WIDTH, 8, PC/IM address width; NOP_INSTR, 16'h0000, bubble encoding.
REQ-002 SHALL have ports: clk input 1, sole clock, all state updates on posedge; rst input 1, synchronous active-low reset.
REQ-003 SHALL have: start_i input 1, leaves IDLE; stall_IF_ID_i input 1, hold PC and IF/ID; flush_IF_ID_i input 1, bubble IF/ID.
REQ-004 SHALL have: JumpD_i input 1, jump decoded in ID; jumpAddr_i input ADDR_WIDTH, jump target; StopD_i input 1, stop decoded in ID.
REQ-005 SHALL have: BranchTakenE_i input 1, branch resolved taken in EX; branchAddrE_i input ADDR_WIDTH, branch target.
REQ-006 SHALL have: instruction_mem_addr_o output ADDR_WIDTH, equals PCF; instruction_mem_rD_i input DATA_WIDTH, combinational IM read data for PCF.
REQ-007 SHALL have: instrD_o output DATA_WIDTH, IF/ID instruction; PCD_o output ADDR_WIDTH, address of instrD_o; validD_o output 1, instrD_o is real.
REQ-008 SHALL have: halted_o output 1, state==HALT; fetch_count_o output 16, valid instructions delivered.

Function
REQ-009 SHALL implement FSM states IDLE, RUN, HALT; IDLE->RUN when start_i=1; RUN->HALT on stop event (REQ-015); HALT exits only via reset.
REQ-010 In IDLE and HALT SHALL hold PCF and load IF/ID with bubble (instrD_o=NOP_INSTR, PCD_o=0, validD_o=0) every cycle.
REQ-011 In RUN SHALL evaluate per cycle with priority: BranchTakenE_i > stall_IF_ID_i > JumpD_i > StopD_i > flush_IF_ID_i > normal.
REQ-012 Branch: PCF<=branchAddrE_i; IF/ID<=bubble; applies even when stall_IF_ID_i=1; StopD_i and JumpD_i ignored that cycle (wrong-path).
REQ-013 Stall (no branch): PCF, instrD_o, PCD_o, validD_o, fetch_count_o hold.
REQ-014 Jump (no branch, no stall): PCF<=jumpAddr_i; IF/ID<=bubble (squash instruction fetched this cycle).
REQ-015 Stop (no branch/stall/jump): state<=HALT; PCF holds; IF/ID<=bubble.
REQ-016 Flush only: IF/ID<=bubble; PCF<=PCF+1.
REQ-017 Normal: instrD_o<=instruction_mem_rD_i; PCD_o<=PCF; validD_o<=1; PCF<=PCF+1.
REQ-018 PC increment SHALL be modulo 2^ADDR_WIDTH (8'hFF+1 -> 8'h00); targets used unmodified.
REQ-019 fetch_count_o SHALL increment by 1 in each cycle a valid instruction loads into IF/ID (REQ-017 only); saturates at 16'hFFFF.
REQ-020 IF/ID load latency SHALL be 1 cycle: instruction at PCF in cycle n appears on instrD_o in cycle n+1.
REQ-021 instruction_mem_addr_o SHALL be driven combinationally from PCF register, no extra pipeline stage.
REQ-022 All inputs SHALL be ignored while rst=0; start_i ignored outside IDLE.

Reset
REQ-023 On posedge clk with rst=0: state<=IDLE, PCF<=0, instrD_o<=NOP_INSTR, PCD_o<=0, validD_o<=0, fetch_count_o<=0; halted_o=0.
REQ-024 Reset asserted mid-RUN or in HALT SHALL take effect at next posedge, discarding in-flight IF/ID contents.

Verification
REQ-025 Reset then start_i pulse, IM returns 16'h1000+addr -> validD_o=1 one cycle after RUN, instrD_o 16'h1000,16'h1001,16'h1002, PCD_o 0,1,2; fetch_count_o 1,2,3.
REQ-026 In RUN at PCF=5, stall_IF_ID_i=1 for 3 cycles -> PCF stays 5, instrD_o/PCD_o/fetch_count_o frozen; fetch resumes at 5 after release.
REQ-027 JumpD_i=1, jumpAddr_i=8'h40 at PCF=7 -> next cycle PCF=8'h40, validD_o=0; following cycle instrD_o=IM[8'h40], PCD_o=8'h40.
REQ-028 BranchTakenE_i=1, branchAddrE_i=8'h20 together with stall_IF_ID_i=1 and StopD_i=1 -> PCF=8'h20, validD_o=0, state stays RUN.
REQ-029 StopD_i=1 alone -> halted_o=1 next cycle, PCF frozen, validD_o=0 thereafter despite start_i pulses; rst=0 -> IDLE, PCF=0.
REQ-030 Run from PCF=8'hFE uninterrupted -> PCD_o sequence 8'hFE, 8'hFF, 8'h00; fetch_count_o preset near max saturates at 16'hFFFF.
